// File: rtl/gps_sample_pacer_if.sv
// Bus between the GPS sample pacer and its neighbours: the front-end sample
// inputs and capture controls on one side, the paced sample stream, status
// and slot-machine debug view on the other.
//
// Handshake: there is no ready. DATAREADY is a one-cycle pulse that opens
// a 4-cycle slot. SAMPLE is stable from the DATAREADY cycle through slot
// cycle 3, and the consumer takes bit k in slot cycle k. Pulses are at
// least 4 cycles apart, so the consumer must always accept a new slot.
interface gps_sample_pacer_if #(
  parameter int FIFO_DEPTH = 8
);
  localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

  logic             GPS_CLK;
  logic             GPS_I0;
  logic             GPS_I1;
  logic             GPS_Q0;
  logic             GPS_Q1;
  logic             ENABLE;
  logic             CLR_OVERRUN;
  logic             DATAREADY;
  logic [3:0]       SAMPLE;
  logic             OVERRUN;
  logic [LVL_W-1:0] FIFO_LEVEL;
  logic             DBG_SLOT_STATE; // 0 = IDLE, 1 = SLOT
  logic [1:0]       DBG_SLOT_CNT;

  modport slave (
    input  GPS_CLK, GPS_I0, GPS_I1, GPS_Q0, GPS_Q1, ENABLE, CLR_OVERRUN,
    output DATAREADY, SAMPLE, OVERRUN, FIFO_LEVEL, DBG_SLOT_STATE, DBG_SLOT_CNT
  );

  modport master (
    output GPS_CLK, GPS_I0, GPS_I1, GPS_Q0, GPS_Q1, ENABLE, CLR_OVERRUN,
    input  DATAREADY, SAMPLE, OVERRUN, FIFO_LEVEL, DBG_SLOT_STATE, DBG_SLOT_CNT
  );
endinterface

// File: rtl/gps_sample_pacer.sv
// GPS sample pacer: brings the front-end sample clock and 2-bit I/Q data
// into MCU_CLK, captures one nibble {Q1,Q0,I1,I0} per GPS_CLK rise into a
// small FIFO and releases them as 4-cycle slots for the SPI bridge.
module gps_sample_pacer #(
  parameter int FIFO_DEPTH  = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 MCU_CLK,
  input  logic                 RESET_N,
  gps_sample_pacer_if.slave    bus
);

  localparam int AW    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;
  localparam int WU_W  = $clog2(SYNC_STAGES + 2);
  localparam logic [WU_W-1:0]  WU_LAST  = WU_W'(SYNC_STAGES + 1);
  localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(FIFO_DEPTH);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_SLOT = 1'b1
  } slot_state_t;

  logic [3:0]       din;
  logic [SYNC_STAGES-1:0] gclk_sync;
  logic [3:0]       data_sync [SYNC_STAGES];
  logic             gsync;
  logic [3:0]       gdata;
  logic             gprev;
  logic [WU_W-1:0]  warm_cnt;
  logic             warmup;
  logic             cap;

  logic [3:0]       mem [FIFO_DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [LVL_W-1:0] level;
  logic             full;
  logic             empty;
  logic             pop;
  logic             push_ok;
  logic             drop;
  logic             overrun;

  slot_state_t      state;
  logic [1:0]       cnt;
  logic             dataready;
  logic [3:0]       sample_q;

  assign din = {bus.GPS_Q1, bus.GPS_Q0, bus.GPS_I1, bus.GPS_I0};

  // Parallel synchroniser chains keep clock and data aligned stage for stage.
  always_ff @(posedge MCU_CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        gclk_sync[i] <= 1'b0;
        data_sync[i] <= 4'h0;
      end
    end else begin
      gclk_sync[0] <= bus.GPS_CLK;
      data_sync[0] <= din;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        gclk_sync[i] <= gclk_sync[i-1];
        data_sync[i] <= data_sync[i-1];
      end
    end
  end

  assign gsync = gclk_sync[SYNC_STAGES-1];
  assign gdata = data_sync[SYNC_STAGES-1];

  // Edge flop plus warm-up counter; the counter hides the artificial rise a
  // GPS_CLK held high through reset would otherwise present.
  always_ff @(posedge MCU_CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      gprev    <= 1'b0;
      warm_cnt <= '0;
    end else begin
      gprev <= gsync;
      if (warm_cnt != WU_LAST) warm_cnt <= warm_cnt + 1'b1;
    end
  end

  assign warmup = (warm_cnt != WU_LAST);
  assign cap    = gsync & ~gprev & bus.ENABLE & ~warmup;

  assign full    = (level == LVL_FULL);
  assign empty   = (level == '0);
  assign pop     = ~empty & ((state == S_IDLE) | ((state == S_SLOT) & (cnt == 2'd3)));
  // A push into a full FIFO still lands if the slot machine frees a place on
  // the same edge.
  assign push_ok = cap & (~full | pop);
  assign drop    = cap & full & ~pop;

  // Sample FIFO storage, pointers and occupancy.
  always_ff @(posedge MCU_CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= 4'h0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= gdata;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  // Sticky overrun flag; a new drop beats a clear on the same edge.
  always_ff @(posedge MCU_CLK or negedge RESET_N) begin
    if (!RESET_N)             overrun <= 1'b0;
    else if (drop)            overrun <= 1'b1;
    else if (bus.CLR_OVERRUN) overrun <= 1'b0;
  end

  // Slot machine: opens a 4-cycle slot per popped sample, back to back while
  // the FIFO has data.
  always_ff @(posedge MCU_CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state     <= S_IDLE;
      cnt       <= 2'd0;
      dataready <= 1'b0;
      sample_q  <= 4'h0;
    end else begin
      dataready <= 1'b0;
      case (state)
        S_IDLE: begin
          cnt <= 2'd0;
          if (!empty) begin
            dataready <= 1'b1;
            sample_q  <= mem[rd_ptr];
            state     <= S_SLOT;
          end
        end
        S_SLOT: begin
          cnt <= cnt + 2'd1;
          if (cnt == 2'd3) begin
            if (!empty) begin
              dataready <= 1'b1;
              sample_q  <= mem[rd_ptr];
            end else begin
              state <= S_IDLE;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.DATAREADY      = dataready;
  assign bus.SAMPLE         = sample_q;
  assign bus.OVERRUN        = overrun;
  assign bus.FIFO_LEVEL     = level;
  assign bus.DBG_SLOT_STATE = state;
  assign bus.DBG_SLOT_CNT   = cnt;

endmodule
